// File: rtl/hemaia_clk_div_ctrl_pkg.sv
// hemaia_clk_div_ctrl_pkg: shared FSM state type and settle-time helper for the divider controller
package hemaia_clk_div_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, APPLY, SETTLE} ctrl_state_e;

  // Worst case for a divider to reach its counter wrap twice at the largest divisor, plus margin.
  function automatic int unsigned default_settle_cycles(int unsigned w);
    return 2 * (2 ** w) + 2;
  endfunction

endpackage

// File: rtl/hemaia_clk_div_rr_arb.sv
// hemaia_clk_div_rr_arb: round-robin arbiter, search starts one past the last granted channel
module hemaia_clk_div_rr_arb #(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [N-1:0]    req,
  input  logic            advance,
  output logic [N-1:0]    gnt,
  output logic [IdxW-1:0] gnt_idx
);

  logic [IdxW-1:0] ptr_q;
  logic [IdxW-1:0] idx;
  logic            found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = IdxW'((32'(ptr_q) + i) % N);
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else if (advance) ptr_q <= (32'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
  end

endmodule

// File: rtl/hemaia_clk_div_ctrl.sv
// hemaia_clk_div_ctrl: queues one divisor per channel and applies them one at a time,
// holding each divisor stable while its divider switches over.
module hemaia_clk_div_ctrl
  import hemaia_clk_div_ctrl_pkg::*;
#(
  parameter int unsigned NumDividers      = 4,
  parameter int unsigned MaxDivisionWidth = 4,
  parameter int unsigned DefaultDivision  = 1,
  parameter int unsigned SettleCycles     = default_settle_cycles(MaxDivisionWidth),
  localparam int unsigned ChanW           = (NumDividers > 1) ? $clog2(NumDividers) : 1
) (
  input  logic                                             clk_i,
  input  logic                                             rst_ni,
  input  logic                                             req_valid_i,
  output logic                                             req_ready_o,
  input  logic [ChanW-1:0]                                 req_chan_i,
  input  logic [MaxDivisionWidth-1:0]                      req_divisor_i,
  output logic [NumDividers-1:0][MaxDivisionWidth-1:0]     divisor_o,
  output logic [NumDividers-1:0]                           divisor_valid_o,
  output logic [NumDividers-1:0]                           pending_o,
  output logic                                             busy_o,
  output logic                                             done_o,
  output logic [ChanW-1:0]                                 done_chan_o
);

  localparam int unsigned CntW      = $clog2(SettleCycles + 1);
  localparam int unsigned ChanSlots = 2 ** ChanW;

  ctrl_state_e state_q, state_d;
  logic [CntW-1:0]                                 cnt_q;
  logic [NumDividers-1:0][MaxDivisionWidth-1:0]    pend_div_q;
  logic [NumDividers-1:0]                          pend_v_q;
  logic [NumDividers-1:0]                          gnt;
  logic [ChanW-1:0]                                gnt_idx;
  logic [ChanW-1:0]                                sel_q;
  logic [ChanSlots-1:0]                            chan_ok;
  logic accept, grant, settle_last, done_d;

  // Channel indices that do not map to a divider are refused at the port.
  assign chan_ok     = {ChanSlots{1'b1}} >> (ChanSlots - NumDividers);
  assign req_ready_o = chan_ok[req_chan_i];
  assign accept      = req_valid_i & req_ready_o;
  assign pending_o   = pend_v_q;

  hemaia_clk_div_rr_arb #(
    .N    (NumDividers),
    .IdxW (ChanW)
  ) i_arb (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .req     (pend_v_q),
    .advance (grant),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    grant       = state_q == IDLE && |pend_v_q;
    settle_last = state_q == SETTLE && cnt_q == CntW'(SettleCycles - 1);
    done_d      = state_q == SETTLE && cnt_q == CntW'(SettleCycles - 2);
    state_d     = state_q;
    unique case (state_q)
      IDLE:    if (grant) state_d = APPLY;
      APPLY:   state_d = SETTLE;
      SETTLE:  if (settle_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are loaded on the grant edge so the APPLY cycle already shows the new divisor and pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      sel_q           <= '0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      done_chan_o     <= '0;
      divisor_valid_o <= '0;
      divisor_o       <= {NumDividers{MaxDivisionWidth'(DefaultDivision)}};
      pend_v_q        <= '0;
      pend_div_q      <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= state_q == SETTLE ? cnt_q + 1'b1 : '0;
      sel_q           <= grant ? gnt_idx : sel_q;
      busy_o          <= state_d != IDLE;
      done_o          <= done_d;
      done_chan_o     <= done_d ? sel_q : done_chan_o;
      divisor_valid_o <= grant ? gnt : '0;
      for (int c = 0; c < NumDividers; c++) begin
        if (grant && gnt[c]) divisor_o[c] <= pend_div_q[c];
        if (accept && req_chan_i == ChanW'(c)) begin
          pend_v_q[c]   <= 1'b1;
          pend_div_q[c] <= req_divisor_i;
        end else if (grant && gnt[c]) begin
          pend_v_q[c] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/hemaia_clk_div_ctrl.md
# hemaia_clk_div_ctrl

Sequencer and arbiter that configures a bank of `NumDividers` HeMAiA clock dividers from one register-side request port. It queues one pending divisor per channel, applies updates one at a time with round-robin fairness, and holds each divisor stable until its divider has switched. It sits in the clock/reset controller between the CSR file and the divider instances, all in the `clk_i` domain.

## Interface
- `NumDividers`, 4, number of divider channels (1..16)
- `MaxDivisionWidth`, 4, divisor width; must match the dividers
- `DefaultDivision`, 1, divisor driven on every channel after reset
- `SettleCycles`, 2*2^MaxDivisionWidth+2, cycles to wait after a valid pulse before the next channel is served
- `clk_i`  in  1  controller and divider reference clock
- `rst_ni`  in  1  reset, asynchronous, active-low
- `req_valid_i`  in  1  update request
- `req_ready_o`  out  1  request accepted when high with `req_valid_i`
- `req_chan_i`  in  ChanW=max(1,$clog2(NumDividers))  target channel
- `req_divisor_i`  in  MaxDivisionWidth  new divisor; 0 means gate the clock
- `divisor_o`  out  NumDividers x MaxDivisionWidth  to each divider's `divisor_i`
- `divisor_valid_o`  out  NumDividers  one-cycle pulse to each divider's `divisor_valid_i`
- `pending_o`  out  NumDividers  channel has an unapplied request
- `busy_o`  out  1  FSM not in IDLE
- `done_o`  out  1  one-cycle pulse when a channel's settle completes
- `done_chan_o`  out  ChanW  channel that completed, valid with `done_o`

## Operation
- Per-channel pending slot: `pend_div[c]` and `pend_v[c]`. An accepted request writes the slot and sets `pend_v`. A second request to a still-pending channel overwrites the divisor; last write wins.
- `req_ready_o` is always 1, except it is 0 for a `req_chan_i` >= NumDividers, which is never accepted.
- FSM:
  - IDLE: if any `pend_v`, round-robin grant starting after the last served channel → APPLY, latch `sel`.
  - APPLY, 1 cycle: `divisor_o[sel] <= pend_div[sel]`, pulse `divisor_valid_o[sel]`, clear `pend_v[sel]` → SETTLE.
  - SETTLE: count to SettleCycles-1, pulse `done_o` with `done_chan_o=sel` → IDLE.
- `divisor_o[c]` changes only in APPLY for `c` and stays stable throughout SETTLE. The divider samples its divisor at its own counter wrap, not at the pulse.
- A request to `sel` that arrives during APPLY or SETTLE re-sets `pend_v[sel]`, and the channel is served again later.
- Accept and clear in the same cycle for the same channel: the accept wins, so `pend_v` stays 1 with the new divisor.
- Divisor 0 is forwarded unchanged; the divider gates its output. No special handling here.
- Round-robin pointer: after serving `c`, the next search starts at `c+1` and wraps to 0 after NumDividers-1.

## Timing
- Reset values:
  - `divisor_o[*]`=DefaultDivision
  - `divisor_valid_o`=0, `pending_o`=0, `busy_o`=0, `done_o`=0, `done_chan_o`=0
  - round-robin pointer = 0, FSM = IDLE
- Latency:
  - Request accepted at cycle T: `pending_o` high at T+1.
  - If the FSM is IDLE at T+1, the grant happens at T+1 and APPLY at T+2.
  - `divisor_valid_o` and the new `divisor_o` are high/valid in cycle T+2 (registered).
  - `done_o` fires at T+2+SettleCycles.
- Throughput: one channel per SettleCycles+2 cycles.
- All outputs are registered; no combinational path from `req_*` to any output except `req_ready_o`.
- Reset mid-SETTLE aborts the update. `divisor_o` returns to DefaultDivision, which matches the divider's own reset.

## Structure
- Package `hemaia_clk_div_ctrl_pkg`:
  - FSM state enum `ctrl_state_e {IDLE, APPLY, SETTLE}`
  - function computing the default SettleCycles from MaxDivisionWidth
- Sub-module `hemaia_clk_div_rr_arb` (NumDividers request vector → one-hot grant plus index, pointer update on `advance`).
- The settle counter is local; its width is $clog2(SettleCycles+1).

## Test plan
- Reset, no requests → `divisor_o` all 1, `busy_o`=0 indefinitely, no valid pulses.
- Request ch2 div=6 at T → `divisor_valid_o[2]` pulse at T+2, `divisor_o[2]`=6 from T+2, `done_o`/`done_chan_o`=2 at T+2+34 (W=4); the attached divider then outputs clk_i/6.
- Same-cycle-burst requests ch0=3, ch1=4, ch3=5, consecutive cycles → applied in order 0,1,3, each valid pulse 36 cycles apart, `pending_o` bits clear at each APPLY.
- Requests ch1=4 then ch1=7 before grant → single APPLY with 7, only one `done_o`.
- Request ch0=5 during SETTLE of ch0 → second APPLY of ch0=5 after the current `done_o`; `divisor_o[0]` unchanged until then.
- Request ch3=0 → `divisor_o[3]`=0, the divider's `clk_o` stops. Then ch3=2 → clock resumes at clk_i/2. Assert rst_ni low mid-SETTLE → all outputs return to reset values immediately.
